// File: rtl/alarm_pkg.sv
// Shared constants for the zone-alarm buzzer interface.
// Zone encoding is also used by the alarm transmitter block, so keep it stable.
// Contents: zone codes, event types, decoder FSM states, evt_data field offsets,
// and small helpers for decoding the one-hot buzzer lines.
package alarm_pkg;

    typedef enum logic [1:0] {
        ZONE_NONE = 2'd0,
        ZONE_1    = 2'd1,
        ZONE_2    = 2'd2,
        ZONE_3    = 2'd3
    } zone_e;

    typedef enum logic [1:0] {
        EVT_GOOD  = 2'd0,
        EVT_SHORT = 2'd1,
        EVT_LONG  = 2'd2,
        EVT_MULTI = 2'd3
    } evt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_ERR_WAIT = 2'd2
    } state_e;

    // evt_data layout: {type, zone, len}, len in the low bits
    localparam int EVT_LEN_LSB = 0;
    localparam int EVT_ZONE_W  = 2;
    localparam int EVT_TYPE_W  = 2;

    function automatic int evt_zone_lsb(input int len_w);
        return len_w;
    endfunction

    function automatic int evt_type_lsb(input int len_w);
        return len_w + EVT_ZONE_W;
    endfunction

    // Maps a single buzzer line to its zone; anything not one-hot is ZONE_NONE.
    function automatic zone_e zone_of(input logic [2:0] line);
        case (line)
            3'b001:  return ZONE_1;
            3'b010:  return ZONE_2;
            3'b100:  return ZONE_3;
            default: return ZONE_NONE;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [2:0] v);
        return (v != 3'd0) && ((v & (v - 3'd1)) == 3'd0);
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Small synchronous first-word-fall-through FIFO for decoded alarm events.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    write request and data; a push while full is accepted only if pop is also set
//   pop          read request; ignored when empty
//   full, empty  status
//   head         entry at the read pointer (valid when !empty)
module evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot being written.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/alarm_event_decoder.sv
// Receive side of the zone-alarm buzzer interface. Measures each pulse on the
// three one-hot buzzer lines, classifies it, and queues an event for the host.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ena                  block enable; low freezes all state and hides evt_valid
//   buzz[2:0]            buzzer lines (bit0 = zone1 .. bit2 = zone3)
//   clr                  clears good_cnt, err_cnt, ovf
//   evt_valid/evt_ready  event handshake, evt_data = {type, zone, len}
//   good_cnt, err_cnt    saturating event counters
//   ovf                  sticky: an event was dropped on a full FIFO
//
// state       | meaning
// ST_IDLE     | all lines low, waiting for a pulse
// ST_ACTIVE   | one line high, counting its length
// ST_ERR_WAIT | error already logged, waiting for all lines low
module alarm_event_decoder
    import alarm_pkg::*;
#(
    parameter int MIN_LEN    = 28,
    parameter int MAX_LEN    = 31,
    parameter int LEN_W      = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [2:0]       buzz,
    input  logic             clr,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [LEN_W+3:0] evt_data,
    output logic [7:0]       good_cnt,
    output logic [7:0]       err_cnt,
    output logic             ovf
);

    localparam int ZONE_LSB = evt_zone_lsb(LEN_W);
    localparam int TYPE_LSB = evt_type_lsb(LEN_W);

    logic [2:0]       buzz_q;
    logic [2:0]       line_q;
    logic [2:0]       line_nxt;
    state_e           state;
    state_e           state_nxt;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_nxt;

    logic             push_req;
    evt_type_e        push_type;
    zone_e            push_zone;
    logic [LEN_W-1:0] push_len;
    logic [LEN_W+3:0] push_word;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LEN_W+3:0] fifo_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buzz_q <= '0;
            line_q <= '0;
            state  <= ST_IDLE;
            len    <= '0;
        end else if (ena) begin
            buzz_q <= buzz;
            line_q <= line_nxt;
            state  <= state_nxt;
            len    <= len_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        line_nxt  = line_q;
        len_nxt   = len;
        push_req  = 1'b0;
        push_type = EVT_GOOD;
        push_zone = ZONE_NONE;
        push_len  = '0;
        case (state)
            ST_IDLE: begin
                if (is_onehot(buzz_q)) begin
                    line_nxt  = buzz_q;
                    len_nxt   = LEN_W'(1);
                    state_nxt = ST_ACTIVE;
                end else if (buzz_q != 3'd0) begin
                    push_req  = 1'b1;
                    push_type = EVT_MULTI;
                    push_len  = LEN_W'(1);
                    state_nxt = ST_ERR_WAIT;
                end
            end
            ST_ACTIVE: begin
                push_zone = zone_of(line_q);
                push_len  = len;
                if (buzz_q == line_q) begin
                    if (len < LEN_W'(MAX_LEN)) begin
                        len_nxt = len + LEN_W'(1);
                    end else begin
                        // Stuck line: log once, then ignore until it drops.
                        push_req  = 1'b1;
                        push_type = EVT_LONG;
                        push_len  = LEN_W'(MAX_LEN + 1);
                        state_nxt = ST_ERR_WAIT;
                    end
                end else if (buzz_q == 3'd0) begin
                    push_req  = 1'b1;
                    push_type = ((len >= LEN_W'(MIN_LEN)) && (len <= LEN_W'(MAX_LEN)))
                                ? EVT_GOOD : EVT_SHORT;
                    state_nxt = ST_IDLE;
                end else begin
                    push_req  = 1'b1;
                    push_type = EVT_MULTI;
                    state_nxt = ST_ERR_WAIT;
                end
            end
            ST_ERR_WAIT: begin
                if (buzz_q == 3'd0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        push_word = '0;
        push_word[EVT_LEN_LSB +: LEN_W]   = push_len;
        push_word[ZONE_LSB +: EVT_ZONE_W] = push_zone;
        push_word[TYPE_LSB +: EVT_TYPE_W] = push_type;
    end

    assign push      = ena && push_req;
    assign evt_valid = ena && !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    assign evt_data  = fifo_empty ? '0 : fifo_head;

    evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (LEN_W + 4)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Counters follow the classification, independent of whether the push fit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= '0;
            err_cnt  <= '0;
            ovf      <= 1'b0;
        end else if (ena) begin
            if (clr) begin
                good_cnt <= '0;
                err_cnt  <= '0;
                ovf      <= 1'b0;
            end else begin
                if (push && push_type == EVT_GOOD && good_cnt != 8'hFF)
                    good_cnt <= good_cnt + 8'd1;
                if (push && push_type != EVT_GOOD && err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
                if (push && fifo_full && !pop)
                    ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alarm_event_decoder.sv
// Directed bench for alarm_event_decoder with an event scoreboard.
module tb_alarm_event_decoder;

    localparam int LEN_W = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic             clr = 1'b0;
    logic             evt_ready = 1'b0;
    logic [2:0]       buzz = 3'd0;
    logic             evt_valid;
    logic [LEN_W+3:0] evt_data;
    logic [7:0]       good_cnt;
    logic [7:0]       err_cnt;
    logic             ovf;

    int total = 0;
    int bad = 0;
    logic [LEN_W+3:0] sb [$];

    always #5 clk = ~clk;

    alarm_event_decoder #(
        .MIN_LEN    (28),
        .MAX_LEN    (31),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .buzz      (buzz),
        .clr       (clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .good_cnt  (good_cnt),
        .err_cnt   (err_cnt),
        .ovf       (ovf)
    );

    function automatic logic [LEN_W+3:0] ev(input logic [1:0] t, input logic [1:0] z, input int l);
        return {t, z, LEN_W'(l)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] l, input int n);
        buzz = l;
        step(n);
        buzz = 3'd0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (!evt_valid && sb.size() == 0) break;
            step(1);
        end
        check({tag, "_sb_left"}, sb.size(), 0);
        check({tag, "_valid"}, evt_valid, 1'b0);
    endtask

    // Scoreboard: every accepted handshake must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL evt_unexpected observed=%0h expected=none", evt_data);
            end else begin
                check("evt_data", evt_data, sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        step(2);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_data", evt_data, 0);
        check("rst_good", good_cnt, 0);
        check("rst_err", err_cnt, 0);
        check("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        ena = 1'b1;
        evt_ready = 1'b1;
        step(2);

        // zone-2 31-cycle pulse with latency check
        sb.push_back(ev(2'b00, 2'd2, 31));
        pulse(3'b010, 31);
        step(1);
        check("lat_early", evt_valid, 1'b0);
        step(1);
        check("lat_valid", evt_valid, 1'b1);
        step(3);
        check("z2_good", good_cnt, 1);
        check("z2_err", err_cnt, 0);

        // short / boundary lengths
        sb.push_back(ev(2'b01, 2'd1, 5));
        pulse(3'b001, 5);
        step(3);
        sb.push_back(ev(2'b00, 2'd3, 28));
        pulse(3'b100, 28);
        step(3);
        sb.push_back(ev(2'b01, 2'd3, 27));
        pulse(3'b100, 27);
        step(3);

        // stuck line: one LONG, then a normal pulse
        sb.push_back(ev(2'b10, 2'd1, 32));
        pulse(3'b001, 50);
        step(3);
        sb.push_back(ev(2'b00, 2'd1, 31));
        pulse(3'b001, 31);
        step(3);
        check("mix_good", good_cnt, 3);
        check("mix_err", err_cnt, 3);
        check("mix_sb_left", sb.size(), 0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clr1_good", good_cnt, 0);
        check("clr1_err", err_cnt, 0);

        // multi-line errors
        sb.push_back(ev(2'b11, 2'd0, 1));
        pulse(3'b011, 10);
        step(3);
        sb.push_back(ev(2'b11, 2'd3, 10));
        buzz = 3'b100;
        step(10);
        buzz = 3'b010;
        step(10);
        buzz = 3'b000;
        step(3);
        check("multi_err", err_cnt, 2);
        check("multi_good", good_cnt, 0);
        check("multi_sb_left", sb.size(), 0);

        // overflow with consumer stalled
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb.push_back(ev(2'b00, 2'd1, 28 + i));
            pulse(3'b001, (i < 4) ? 28 + i : 30);
            step(3);
        end
        check("ovf_set", ovf, 1'b1);
        check("ovf_good", good_cnt, 5);
        check("ovf_valid", evt_valid, 1'b1);
        check("ovf_head", evt_data, sb[0]);
        step(3);
        check("ovf_hold", evt_data, sb[0]);
        evt_ready = 1'b1;
        drain("ovf_drain");
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clr2_ovf", ovf, 1'b0);
        check("clr2_good", good_cnt, 0);
        check("clr2_err", err_cnt, 0);

        // reset in the middle of a pulse, with one event pending
        evt_ready = 1'b0;
        sb.push_back(ev(2'b00, 2'd2, 29));
        pulse(3'b010, 29);
        step(3);
        check("pre_rst_valid", evt_valid, 1'b1);
        check("pre_rst_good", good_cnt, 1);
        buzz = 3'b010;
        step(15);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", evt_valid, 1'b0);
        check("mid_rst_data", evt_data, 0);
        check("mid_rst_good", good_cnt, 0);
        check("mid_rst_ovf", ovf, 1'b0);
        buzz = 3'b000;
        step(2);
        sb.delete();
        rst_n = 1'b1;
        evt_ready = 1'b1;
        step(5);
        check("post_rst_valid", evt_valid, 1'b0);
        check("post_rst_good", good_cnt, 0);
        check("post_rst_err", err_cnt, 0);

        // enable gap inside a pulse is not counted
        sb.push_back(ev(2'b00, 2'd1, 30));
        buzz = 3'b001;
        step(10);
        ena = 1'b0;
        step(10);
        ena = 1'b1;
        step(20);
        buzz = 3'b000;
        step(3);
        check("ena_gap_good", good_cnt, 1);
        check("ena_gap_sb_left", sb.size(), 0);

        // evt_valid hidden while disabled
        evt_ready = 1'b0;
        sb.push_back(ev(2'b00, 2'd2, 29));
        pulse(3'b010, 29);
        step(3);
        ena = 1'b0;
        step(1);
        check("ena_off_valid", evt_valid, 1'b0);
        check("ena_off_good", good_cnt, 2);
        ena = 1'b1;
        step(1);
        check("ena_on_valid", evt_valid, 1'b1);
        evt_ready = 1'b1;
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
